// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: request/response channel bundle for the ALU sequencing front-end.
// master = instruction issuer / result consumer, slave = alu_ctrl.
interface alu_ctrl_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cls;
    logic [3:0]  req_fn;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic [63:0] req_imm;
    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_wb_en;
    logic        rsp_taken;
    logic        rsp_illegal;
    logic        rsp_div0;

    modport master (
        output req_valid, req_cls, req_fn, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_wb_en, rsp_taken, rsp_illegal, rsp_div0,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_cls, req_fn, req_rs1, req_rs2, req_imm,
        output req_ready,
        output rsp_valid, rsp_result, rsp_wb_en, rsp_taken, rsp_illegal, rsp_div0,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing front-end for the 64-bit combinational ALU.
// Accepts a decoded instruction, drives ALU A/B/op (held across the multicycle
// window for mul/div), captures ALUOut/zero_flag, resolves CBZ/CBNZ and returns
// the result on a valid/ready response channel.
// Optional feature: define ALU_CTRL_DIV0_CHK_EN to intercept divide-by-zero
// (op 1111 with B == 0) without driving the ALU.
module alu_ctrl #(
    parameter int unsigned MULDIV_WAIT = 3   // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_ctrl_if.slave   bus,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_CBZ, BR_CBNZ} br_t;

    // Everything the ALU needs for one instruction, captured on accept.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic        wb;
        br_t         br;
        logic        muldiv;
    } issue_t;

    typedef struct packed {
        logic [63:0] result;
        logic        wb_en;
        logic        taken;
        logic        illegal;
    } rsp_t;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_PASS_B = 4'b1010;
    localparam logic [3:0] OP_PASS_A = 4'b1011;
    localparam logic [3:0] OP_MUL    = 4'b1110;
    localparam logic [3:0] OP_DIV    = 4'b1111;

    // A single-cycle hold means mul/div leaves EXEC directly like any other op.
    localparam bit         HAS_WAIT  = (MULDIV_WAIT > 1);
    localparam logic [3:0] WAIT_LAST = 4'(MULDIV_WAIT - 32'd1);

    state_t     state_q, state_d;
    logic       init_q, init_d;
    issue_t     iss_q, iss_d;
    rsp_t       rsp_q, rsp_d;
    logic [3:0] cnt_q, cnt_d;
`ifdef ALU_CTRL_DIV0_CHK_EN
    logic       div0_q, div0_d;
`endif

    issue_t dec;
    logic   dec_legal;
    logic   dec_div0;
    logic   accept;
    rsp_t   rsp_cap;

    // Decode the incoming request into ALU operands, op-code and response attributes.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        dec       = '0;
        dec_legal = 1'b1;
        case (bus.req_cls)
            3'b000: begin dec.op = bus.req_fn; dec.a = bus.req_rs1; dec.b = bus.req_rs2; dec.wb = 1'b1; end
            3'b001: begin dec.op = bus.req_fn; dec.a = bus.req_rs1; dec.b = bus.req_imm; dec.wb = 1'b1; end
            3'b010: begin dec.op = OP_ADD;     dec.a = bus.req_rs1; dec.b = bus.req_imm; end
            3'b011: begin dec.op = OP_PASS_A;  dec.a = bus.req_rs1; dec.br = BR_CBZ;  end
            3'b100: begin dec.op = OP_PASS_A;  dec.a = bus.req_rs1; dec.br = BR_CBNZ; end
            3'b101: begin dec.op = OP_PASS_B;  dec.b = bus.req_imm; dec.wb = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
        // Only R/I classes can carry a mul/div op-code; the others are fixed.
        dec.muldiv = dec_legal && ((dec.op == OP_MUL) || (dec.op == OP_DIV));
`ifdef ALU_CTRL_DIV0_CHK_EN
        dec_div0 = dec_legal && (dec.op == OP_DIV) && (dec.b == '0);
`else
        dec_div0 = 1'b0;
`endif
    end

    // Handshakes: ready only in IDLE, and not until the first clock after reset.
    assign bus.req_ready = init_q && (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // Response as it would be captured from the ALU on the final EXEC/WAIT edge.
    always_comb begin
        rsp_cap         = '0;
        rsp_cap.result  = alu_result;
        rsp_cap.wb_en   = iss_q.wb;
        rsp_cap.taken   = (iss_q.br == BR_CBZ)  ?  alu_zero :
                          (iss_q.br == BR_CBNZ) ? !alu_zero : 1'b0;
    end

    // Next-state and register-update logic for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        init_d  = 1'b1;
        iss_d   = iss_q;
        rsp_d   = rsp_q;
        cnt_d   = cnt_q;
`ifdef ALU_CTRL_DIV0_CHK_EN
        div0_d  = div0_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    iss_d = dec;
                    cnt_d = '0;
                    if (!dec_legal) begin
                        state_d       = RESP;
                        rsp_d         = '0;
                        rsp_d.illegal = 1'b1;
                    end else if (dec_div0) begin
                        state_d      = RESP;
                        rsp_d        = '0;
                        rsp_d.result = '1;
                        rsp_d.wb_en  = 1'b1;
`ifdef ALU_CTRL_DIV0_CHK_EN
                        div0_d       = 1'b1;
`endif
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (iss_q.muldiv && HAS_WAIT) begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = RESP;
                    rsp_d   = rsp_cap;
                end
            end
            WAIT: begin
                if (cnt_q >= WAIT_LAST) begin
                    state_d = RESP;
                    rsp_d   = rsp_cap;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rsp_d   = '0;
`ifdef ALU_CTRL_DIV0_CHK_EN
                    div0_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, issue and response registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            iss_q   <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q <= state_d;
            init_q  <= init_d;
            iss_q   <= iss_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_CTRL_DIV0_CHK_EN
    // Divide-by-zero flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_q <= 1'b0;
        else        div0_q <= div0_d;
    end
    assign bus.rsp_div0 = div0_q;
`else
    assign bus.rsp_div0 = 1'b0;
`endif

    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_result  = rsp_q.result;
    assign bus.rsp_wb_en   = rsp_q.wb_en;
    assign bus.rsp_taken   = rsp_q.taken;
    assign bus.rsp_illegal = rsp_q.illegal;

    // ALU inputs carry the held operands only while executing; zero otherwise.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if ((state_q == EXEC) || (state_q == WAIT)) begin
            alu_a  = iss_q.a;
            alu_b  = iss_q.b;
            alu_op = iss_q.op;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed self-checking bench for alu_ctrl (MULDIV_WAIT = 3).
// Expectations for divide-by-zero follow whether ALU_CTRL_DIV0_CHK_EN is defined.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    int          checks = 0;
    int          errors = 0;

    alu_ctrl_if bus ();

    alu_ctrl #(.MULDIV_WAIT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU feeding the controller.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_b;
            4'b1011: alu_result = alu_a;
            4'b1110: alu_result = alu_a * alu_b;
            4'b1111: alu_result = (alu_b == '0) ? '1 : alu_a / alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Present a request once req_ready is seen; returns 1 time unit after the accept edge.
    task automatic do_accept(input logic [2:0] cls, input logic [3:0] fn,
                             input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", bus.req_ready); end
        bus.req_cls = cls; bus.req_fn = fn; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Count cycles (accept edge = 1) until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req_cls = '0; bus.req_fn = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op} !== '0) begin errors++; $display("FAIL rst_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
        checks++; if ({bus.rsp_result, bus.rsp_wb_en, bus.rsp_taken, bus.rsp_illegal, bus.rsp_div0} !== '0) begin
            errors++; $display("FAIL rst_rsp_fields: got %h want 0", bus.rsp_result); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_clk: got %b want 0", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_clk: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_r_add();
        int lat;
        do_accept(3'b000, 4'b0000, 64'd5, 64'd7, 64'd0);
        checks++; if ({alu_a, alu_b, alu_op} !== {64'd5, 64'd7, 4'b0000}) begin
            errors++; $display("FAIL add_exec_alu: got %0d/%0d/%b want 5/7/0000", alu_a, alu_b, alu_op); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL add_exec_ready: got %b want 0", bus.req_ready); end
        wait_rsp(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
        checks++; if (bus.rsp_result !== 64'd12) begin errors++; $display("FAIL add_result: got %0d want 12", bus.rsp_result); end
        checks++; if ({bus.rsp_wb_en, bus.rsp_taken, bus.rsp_illegal} !== 3'b100) begin
            errors++; $display("FAIL add_flags: got %b want 100", {bus.rsp_wb_en, bus.rsp_taken, bus.rsp_illegal}); end
        checks++; if ({alu_a, alu_op} !== '0) begin errors++; $display("FAIL add_resp_alu_idle: got %h/%b want 0", alu_a, alu_op); end
        handshake();
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            errors++; $display("FAIL add_after_hs: got valid/ready %b want 01", {bus.rsp_valid, bus.req_ready}); end
    endtask

    task automatic test_branch();
        int lat;
        do_accept(3'b011, 4'b0000, 64'd0, 64'd3, 64'd4);
        wait_rsp(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL cbz_latency: got %0d want 2", lat); end
        checks++; if ({bus.rsp_taken, bus.rsp_wb_en} !== 2'b10) begin
            errors++; $display("FAIL cbz_zero: got taken/wb %b want 10", {bus.rsp_taken, bus.rsp_wb_en}); end
        handshake();
        do_accept(3'b100, 4'b0000, 64'd0, 64'd3, 64'd4);
        wait_rsp(lat);
        checks++; if ({bus.rsp_taken, bus.rsp_wb_en} !== 2'b00) begin
            errors++; $display("FAIL cbnz_zero: got taken/wb %b want 00", {bus.rsp_taken, bus.rsp_wb_en}); end
        handshake();
        do_accept(3'b100, 4'b0000, 64'd5, 64'd0, 64'd0);
        wait_rsp(lat);
        checks++; if ({bus.rsp_taken, bus.rsp_wb_en, bus.rsp_result} !== {2'b10, 64'd5}) begin
            errors++; $display("FAIL cbnz_nonzero: got taken/wb %b result %0d want 10/5", {bus.rsp_taken, bus.rsp_wb_en}, bus.rsp_result); end
        handshake();
    endtask

    task automatic test_classes();
        int lat;
        // I-type subtract uses imm, not rs2
        do_accept(3'b001, 4'b0001, 64'd20, 64'd99, 64'd8);
        wait_rsp(lat);
        checks++; if ({bus.rsp_result, bus.rsp_wb_en} !== {64'd12, 1'b1}) begin
            errors++; $display("FAIL itype_sub: got %0d wb %b want 12 wb 1", bus.rsp_result, bus.rsp_wb_en); end
        handshake();
        // address generation ignores req_fn (a divide code here) and never writes back
        do_accept(3'b010, 4'b1111, 64'h1000, 64'd1, 64'h20);
        wait_rsp(lat);
        checks++; if ({lat[3:0], bus.rsp_result, bus.rsp_wb_en} !== {4'd2, 64'h1020, 1'b0}) begin
            errors++; $display("FAIL addr_gen: got lat %0d result %h wb %b want 2/1020/0", lat, bus.rsp_result, bus.rsp_wb_en); end
        handshake();
        // MOVZ passes the full 64-bit immediate through B with A forced to zero
        do_accept(3'b101, 4'b0000, 64'h55, 64'h66, 64'hDEAD_BEEF_0000_1234);
        checks++; if ({alu_a, alu_op} !== {64'd0, 4'b1010}) begin
            errors++; $display("FAIL movz_exec: got a %h op %b want 0/1010", alu_a, alu_op); end
        wait_rsp(lat);
        checks++; if ({bus.rsp_result, bus.rsp_wb_en} !== {64'hDEAD_BEEF_0000_1234, 1'b1}) begin
            errors++; $display("FAIL movz_result: got %h wb %b want deadbeef00001234 wb 1", bus.rsp_result, bus.rsp_wb_en); end
        handshake();
        // upper bits survive the round trip
        do_accept(3'b000, 4'b0000, 64'hF000_0000_0000_0000, 64'hFF, 64'd0);
        wait_rsp(lat);
        checks++; if (bus.rsp_result !== 64'hF000_0000_0000_00FF) begin
            errors++; $display("FAIL wide_add: got %h want f0000000000000ff", bus.rsp_result); end
        handshake();
    endtask

    task automatic test_muldiv();
        int lat;
        do_accept(3'b001, 4'b1110, 64'd6, 64'd0, 64'd9);
        for (int c = 1; c <= 3; c++) begin
            checks++; if ({alu_a, alu_b, alu_op, bus.rsp_valid} !== {64'd6, 64'd9, 4'b1110, 1'b0}) begin
                errors++; $display("FAIL mul_hold_c%0d: got %0d/%0d/%b valid %b want 6/9/1110 valid 0", c, alu_a, alu_b, alu_op, bus.rsp_valid); end
            @(posedge clk); #1;
        end
        checks++; if ({bus.rsp_valid, bus.rsp_result} !== {1'b1, 64'd54}) begin
            errors++; $display("FAIL mul_result: got valid %b result %0d want 1/54", bus.rsp_valid, bus.rsp_result); end
        handshake();
        do_accept(3'b000, 4'b1111, 64'd100, 64'd7, 64'd0);
        wait_rsp(lat);
        checks++; if ({lat[3:0], bus.rsp_result, bus.rsp_div0} !== {4'd4, 64'd14, 1'b0}) begin
            errors++; $display("FAIL div_normal: got lat %0d result %0d div0 %b want 4/14/0", lat, bus.rsp_result, bus.rsp_div0); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        do_accept(3'b000, 4'b0000, 64'd100, 64'd23, 64'd0);
        wait_rsp(lat);
        // a request offered while busy must be ignored
        bus.req_cls = 3'b110; bus.req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_wb_en, bus.req_ready} !== {1'b1, 64'd123, 1'b1, 1'b0}) begin
                errors++; $display("FAIL bp_hold_c%0d: got valid %b result %0d wb %b ready %b want 1/123/1/0",
                                   c, bus.rsp_valid, bus.rsp_result, bus.rsp_wb_en, bus.req_ready); end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        handshake();
        checks++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_illegal} !== 3'b010) begin
            errors++; $display("FAIL bp_after_hs: got valid/ready/illegal %b want 010", {bus.rsp_valid, bus.req_ready, bus.rsp_illegal}); end
    endtask

    task automatic test_illegal();
        do_accept(3'b110, 4'b0000, 64'd5, 64'd7, 64'd9);
        checks++; if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_wb_en, bus.rsp_taken} !== 4'b1100) begin
            errors++; $display("FAIL ill110_flags: got valid/ill/wb/taken %b want 1100",
                               {bus.rsp_valid, bus.rsp_illegal, bus.rsp_wb_en, bus.rsp_taken}); end
        checks++; if ({bus.rsp_result, alu_a, alu_b, alu_op} !== '0) begin
            errors++; $display("FAIL ill110_zero: got result %h alu %h/%h/%b want 0", bus.rsp_result, alu_a, alu_b, alu_op); end
        handshake();
        do_accept(3'b111, 4'b0000, 64'd3, 64'd3, 64'd3);
        checks++; if ({bus.rsp_valid, bus.rsp_illegal, bus.rsp_result} !== {2'b11, 64'd0}) begin
            errors++; $display("FAIL ill111: got valid/ill %b result %h want 11/0", {bus.rsp_valid, bus.rsp_illegal}, bus.rsp_result); end
        handshake();
    endtask

    task automatic test_div0();
        int lat;
        do_accept(3'b000, 4'b1111, 64'd100, 64'd0, 64'd0);
`ifdef ALU_CTRL_DIV0_CHK_EN
        checks++; if ({bus.rsp_valid, bus.rsp_div0, bus.rsp_wb_en, bus.rsp_result} !== {3'b111, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            errors++; $display("FAIL div0_intercept: got valid/div0/wb %b result %h want 111/all ones",
                               {bus.rsp_valid, bus.rsp_div0, bus.rsp_wb_en}, bus.rsp_result); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL div0_alu_idle: got %b want 0000", alu_op); end
`else
        checks++; if (alu_op !== 4'b1111) begin errors++; $display("FAIL div0_issued: got %b want 1111", alu_op); end
        wait_rsp(lat);
        checks++; if ({lat[3:0], bus.rsp_div0, bus.rsp_result} !== {4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            errors++; $display("FAIL div0_plain: got lat %0d div0 %b result %h want 4/0/all ones", lat, bus.rsp_div0, bus.rsp_result); end
`endif
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        int bad = 0;
        do_accept(3'b000, 4'b1110, 64'd3, 64'd4, 64'd0);
        @(posedge clk); #1;
        checks++; if (alu_op !== 4'b1110) begin errors++; $display("FAIL rmid_in_wait: got %b want 1110", alu_op); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({alu_a, alu_b, alu_op, bus.req_ready, bus.rsp_valid} !== '0) begin
            errors++; $display("FAIL rmid_outputs: got alu %h/%h/%b ready %b valid %b want 0",
                               alu_a, alu_b, alu_op, bus.req_ready, bus.rsp_valid); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d valid cycles want 0", bad); end
        do_accept(3'b000, 4'b0000, 64'd1, 64'd2, 64'd0);
        wait_rsp(lat);
        checks++; if ({lat[3:0], bus.rsp_result} !== {4'd2, 64'd3}) begin
            errors++; $display("FAIL rmid_next: got lat %0d result %0d want 2/3", lat, bus.rsp_result); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_branch();
        test_classes();
        test_muldiv();
        test_backpressure();
        test_illegal();
        test_div0();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front-end for the 64-bit combinational ALU in the single-cycle/multicycle datapath. Accepts a decoded instruction over a valid/ready request channel, drives the ALU operand and op-code inputs, and holds multiply/divide operands stable for a configurable multicycle window. It captures ALUOut/zero_flag, resolves CBZ/CBNZ branches, and returns the result on a valid/ready response channel.

## Interface
- `MULDIV_WAIT`, 3: cycles ALU inputs are held for op 1110/1111 before capture (legal range 1..15).
- `clk`  in  1  clock; all registers update on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high with `req_valid`.
- `req_cls`  in  3  instruction class (see Operation).
- `req_fn`  in  4  ALU function for R/I classes.
- `req_rs1`, `req_rs2`, `req_imm`  in  64 each  operand values.
- `alu_a`, `alu_b`  out  64 each  to ALU A/B.
- `alu_op`  out  4  to ALU op.
- `alu_result`  in  64  from ALUOut.
- `alu_zero`  in  1  from zero_flag.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  64  captured result.
- `rsp_wb_en`  out  1  result is to be written back.
- `rsp_taken`  out  1  branch taken.
- `rsp_illegal`  out  1  unsupported class.
- `rsp_div0`  out  1  divide by zero intercepted.

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP. Request fields are registered on acceptance.
- Class decode (op / A / B / wb):
  - 000 R-type: `req_fn` / rs1 / rs2 / 1.
  - 001 I-type: `req_fn` / rs1 / imm / 1.
  - 010 address generation: 0000 (add) / rs1 / imm / 0; the result is the address.
  - 011 CBZ: 1011 (pass A) / rs1 / 0 / 0; `rsp_taken` = `alu_zero`.
  - 100 CBNZ: same ALU inputs as CBZ; `rsp_taken` = !`alu_zero`.
  - 101 MOVZ: 1010 (pass B) / 0 / imm / 1.
  - 110, 111: illegal. The ALU is not driven; response has `rsp_illegal`=1, result 0, and `rsp_wb_en`/`rsp_taken`=0.
- Transitions:
  - IDLE->EXEC on accept (legal class).
  - IDLE->RESP on accept (illegal class, or div0 intercept).
  - EXEC->RESP for single-cycle ops, or mul/div when MULDIV_WAIT=1.
  - EXEC->WAIT for mul/div when MULDIV_WAIT>1.
  - WAIT->RESP after MULDIV_WAIT-1 WAIT cycles.
  - RESP->IDLE when `rsp_ready`.
- `alu_a`, `alu_b` and `alu_op` carry decoded values only in EXEC/WAIT and are all-zero otherwise. They are held constant across EXEC/WAIT.
- `rsp_result` and `rsp_taken` capture `alu_result`/`alu_zero` on the final EXEC/WAIT edge.
- No width change: 64-bit pass-through, no truncation or extension.

## Timing
- Reset (async): state IDLE, counter 0, every output 0 including `req_ready`. `req_ready` rises on the first clock after `rst_n` deasserts.
- `req_ready` = 1 only in IDLE. There are no back-to-back accepts; the minimum spacing is 3 cycles (accept, EXEC, RESP).
- Latency from accept edge to `rsp_valid` high:
  - 2 cycles for single-cycle ops.
  - 1+MULDIV_WAIT cycles for mul/div.
  - 1 cycle for illegal/div0.
- All `rsp_*` outputs stay stable while `rsp_valid` && !`rsp_ready`. `rsp_valid` falls the cycle after the handshake.
- Reset mid-operation aborts; no response is emitted for the aborted request.
- `req_valid` in a non-IDLE state is ignored (not accepted).

## Configuration
- `ALU_CTRL_DIV0_CHK_EN` defined: for op 1111 with operand B == 0:
  - the ALU is not driven;
  - the response is `rsp_result`=64'hFFFF_FFFF_FFFF_FFFF, `rsp_div0`=1, `rsp_wb_en`=1;
  - IDLE->RESP.
- Undefined: the division is issued normally with the MULDIV_WAIT hold, and `rsp_div0` is tied 0.

## Test plan
- R-type add, rs1=5, rs2=7: `alu_op`=0000 in EXEC, `rsp_result`=12, `rsp_wb_en`=1, `rsp_valid` 2 cycles after accept.
- CBZ with rs1=0, then CBNZ with rs1=0: `rsp_taken`=1 then 0, `rsp_wb_en`=0 for both.
- I-type multiply 1110, rs1=6, imm=9, MULDIV_WAIT=3: `alu_a`/`alu_b`/`alu_op` stable for 3 cycles, `rsp_result`=54, `rsp_valid` 4 cycles after accept.
- `rsp_ready` held low for 5 cycles: `rsp_*` stay constant and `req_ready`=0 throughout; `req_ready`=1 the cycle after the handshake.
- Class 110: `rsp_illegal`=1, `rsp_result`=0, `alu_*` stay 0. Divide 100/0 with `ALU_CTRL_DIV0_CHK_EN`: `rsp_div0`=1, result all ones.
- Assert `rst_n` low during WAIT: all outputs go 0 immediately and no `rsp_valid` follows; the next request completes normally.
